// File: rtl/rf_ctrl_pkg.sv
// ============================================================================
// Module   : rf_ctrl_pkg
// Brief    : Shared widths and types for the register-file write-port control.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rf_ctrl_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    typedef enum logic {
        ARB_NORMAL   = 1'b0,
        ARB_FORCE_LU = 1'b1
    } arb_state_e;

    typedef logic [REG_AW-1:0] reg_addr_t;

endpackage : rf_ctrl_pkg

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// Module   : rf_scoreboard
// Brief    : Pending-destination vector with set/clear and three lookups.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rf_scoreboard
    import rf_ctrl_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_set_en,
    input  reg_addr_t       i_set_addr,
    input  logic            i_clr_en,
    input  reg_addr_t       i_clr_addr,
    input  reg_addr_t       i_rs1_addr,
    input  reg_addr_t       i_rs2_addr,
    input  reg_addr_t       i_rd_addr,
    output logic [NREG-1:0] o_pending,
    output logic            o_rs1_hit,
    output logic            o_rs2_hit,
    output logic            o_rd_hit
);

    localparam logic [NREG-1:0] c_ONE = {{(NREG-1){1'b0}}, 1'b1};

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_next;

    always_comb begin
        w_set_mask = i_set_en ? (c_ONE << i_set_addr) : '0;
        w_clr_mask = i_clr_en ? (c_ONE << i_clr_addr) : '0;
        // Set is applied after clear so a same-register set/clear keeps it pending.
        w_next     = ((r_pending & ~w_clr_mask) | w_set_mask) & ~c_ONE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_next;
        end
    end

    assign o_pending = r_pending;
    assign o_rs1_hit = r_pending[i_rs1_addr];
    assign o_rs2_hit = r_pending[i_rs2_addr];
    assign o_rd_hit  = r_pending[i_rd_addr];

endmodule : rf_scoreboard

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module   : rf_wb_arbiter
// Brief    : Shares the RF write port between core writeback and the LU, with
//            starvation forcing and a RAW/WAW scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rf_wb_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_core_wren,
    input  reg_addr_t       i_core_rd_addr,
    input  logic [XLEN-1:0] i_core_rd_data,
    input  reg_addr_t       i_core_rs1_addr,
    input  reg_addr_t       i_core_rs2_addr,
    input  logic            i_lu_issue,
    input  reg_addr_t       i_lu_issue_rd,
    input  logic            i_lu_valid,
    input  reg_addr_t       i_lu_rd_addr,
    input  logic [XLEN-1:0] i_lu_rd_data,
    output logic            o_lu_ready,
    output logic            o_core_stall,
    output logic            o_hazard,
    output logic            o_rd_wren,
    output reg_addr_t       o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic [NREG-1:0] o_pending
);

    localparam int                c_CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STARVE_LIMIT - 1);

    arb_state_e         r_state;
    logic [c_CNT_W-1:0] r_wait_cnt;

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_rd_hit;
    logic w_hazard;
    logic w_stall;
    logic w_core_eff;
    logic w_lu_grant;
    logic w_issue_set;
    logic w_lu_clr;

    always_comb begin
        w_hazard    = w_rs1_hit | w_rs2_hit | (i_core_wren & w_rd_hit);
        w_stall     = w_hazard | ((r_state == ARB_FORCE_LU) & i_lu_valid);
        w_core_eff  = i_core_wren & ~w_stall & i_rst_n;
        w_lu_grant  = i_lu_valid & i_rst_n & ((r_state == ARB_FORCE_LU) | ~w_core_eff);
        w_issue_set = i_lu_issue & ~w_stall & (i_lu_issue_rd != '0);
        w_lu_clr    = w_lu_grant & (i_lu_rd_addr != '0);
    end

    // Writes to x0 still occupy the port and complete the handshake, but never reach the RF.
    always_comb begin
        o_rd_wren = 1'b0;
        o_rd_addr = '0;
        o_rd_data = '0;
        if (w_lu_grant) begin
            o_rd_wren = (i_lu_rd_addr != '0);
            o_rd_addr = i_lu_rd_addr;
            o_rd_data = i_lu_rd_data;
        end else if (w_core_eff) begin
            o_rd_wren = (i_core_rd_addr != '0);
            o_rd_addr = i_core_rd_addr;
            o_rd_data = i_core_rd_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ARB_NORMAL;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ARB_NORMAL: begin
                    if (i_lu_valid && !w_lu_grant) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (r_wait_cnt == c_CNT_LAST) begin
                            r_state <= ARB_FORCE_LU;
                        end
                    end else begin
                        r_wait_cnt <= '0;
                    end
                end
                ARB_FORCE_LU: begin
                    if (w_lu_grant || !i_lu_valid) begin
                        r_state    <= ARB_NORMAL;
                        r_wait_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= ARB_NORMAL;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    rf_scoreboard u_scoreboard (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_set_en   (w_issue_set),
        .i_set_addr (i_lu_issue_rd),
        .i_clr_en   (w_lu_clr),
        .i_clr_addr (i_lu_rd_addr),
        .i_rs1_addr (i_core_rs1_addr),
        .i_rs2_addr (i_core_rs2_addr),
        .i_rd_addr  (i_core_rd_addr),
        .o_pending  (o_pending),
        .o_rs1_hit  (w_rs1_hit),
        .o_rs2_hit  (w_rs2_hit),
        .o_rd_hit   (w_rd_hit)
    );

    assign o_lu_ready   = w_lu_grant;
    assign o_core_stall = w_stall;
    assign o_hazard     = w_hazard;

endmodule : rf_wb_arbiter

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Brief    : Directed self-checking bench for rf_wb_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;
    import rf_ctrl_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            core_wren;
    reg_addr_t       core_rd, rs1, rs2;
    logic [XLEN-1:0] core_data;
    logic            lu_issue;
    reg_addr_t       lu_issue_rd;
    logic            lu_valid;
    reg_addr_t       lu_rd;
    logic [XLEN-1:0] lu_data;
    logic            lu_ready, core_stall, hazard, rd_wren;
    reg_addr_t       rd_addr;
    logic [XLEN-1:0] rd_data;
    logic [NREG-1:0] pending;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_core_wren     (core_wren),
        .i_core_rd_addr  (core_rd),
        .i_core_rd_data  (core_data),
        .i_core_rs1_addr (rs1),
        .i_core_rs2_addr (rs2),
        .i_lu_issue      (lu_issue),
        .i_lu_issue_rd   (lu_issue_rd),
        .i_lu_valid      (lu_valid),
        .i_lu_rd_addr    (lu_rd),
        .i_lu_rd_data    (lu_data),
        .o_lu_ready      (lu_ready),
        .o_core_stall    (core_stall),
        .o_hazard        (hazard),
        .o_rd_wren       (rd_wren),
        .o_rd_addr       (rd_addr),
        .o_rd_data       (rd_data),
        .o_pending       (pending)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one cycle; inputs are then changed at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        core_wren = 0; core_rd = '0; core_data = '0; rs1 = '0; rs2 = '0;
        lu_issue = 0; lu_issue_rd = '0; lu_valid = 0; lu_rd = '0; lu_data = '0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        @(negedge clk);
        core_wren = 1; core_rd = 5'd5; lu_valid = 1; lu_rd = 5'd6;
        #1;
        check("rst_wren", rd_wren, 0);
        check("rst_ready", lu_ready, 0);
        check("rst_pending", pending, 0);
        tick();
        idle();
        rst_n = 1;
        tick();

        // Core-only writeback
        core_wren = 1; core_rd = 5'd5; core_data = 32'hDEADBEEF;
        #1;
        check("t1_wren", rd_wren, 1);
        check("t1_addr", rd_addr, 5);
        check("t1_data", rd_data, 32'hDEADBEEF);
        check("t1_stall", core_stall, 0);
        check("t1_ready", lu_ready, 0);
        tick();

        // Contention: LU starved four cycles then forced
        core_data = 32'h55; lu_valid = 1; lu_rd = 5'd7; lu_data = 32'h11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t2_ready_c%0d", i), lu_ready, 0);
            check($sformatf("t2_addr_c%0d", i), rd_addr, 5);
            tick();
        end
        #1;
        check("t2_force_ready", lu_ready, 1);
        check("t2_force_addr", rd_addr, 7);
        check("t2_force_data", rd_data, 32'h11);
        check("t2_force_stall", core_stall, 1);
        tick();
        #1;
        check("t2_back_ready", lu_ready, 0);
        check("t2_back_addr", rd_addr, 5);
        check("t2_back_stall", core_stall, 0);
        idle();
        tick();

        // RAW hazard on LU destination x3
        lu_issue = 1; lu_issue_rd = 5'd3;
        #1;
        check("t3_issue_stall", core_stall, 0);
        tick();
        lu_issue = 0; rs1 = 5'd3;
        #1;
        check("t3_pending", pending, 32'h8);
        check("t3_hazard", hazard, 1);
        check("t3_stall", core_stall, 1);
        lu_issue = 1; lu_issue_rd = 5'd4;
        tick();
        lu_issue = 0; rs1 = '0; core_wren = 1; core_rd = 5'd3; core_data = 32'h99;
        #1;
        check("t3_issue_blocked", pending, 32'h8);
        check("t3_waw_hazard", hazard, 1);
        check("t3_waw_wren", rd_wren, 0);
        core_wren = 0; rs1 = 5'd3; lu_valid = 1; lu_rd = 5'd3; lu_data = 32'h33;
        #1;
        check("t3_ret_ready", lu_ready, 1);
        check("t3_ret_addr", rd_addr, 3);
        check("t3_ret_data", rd_data, 32'h33);
        check("t3_ret_hazard", hazard, 1);
        tick();
        lu_valid = 0;
        #1;
        check("t3_clr_pending", pending, 0);
        check("t3_clr_hazard", hazard, 0);
        check("t3_clr_stall", core_stall, 0);
        idle();
        tick();

        // Writes to x0
        core_wren = 1; core_rd = '0; core_data = 32'hAA;
        #1;
        check("t4_core_x0_wren", rd_wren, 0);
        core_wren = 0; lu_valid = 1; lu_rd = '0; lu_data = 32'hBB;
        #1;
        check("t4_lu_x0_ready", lu_ready, 1);
        check("t4_lu_x0_wren", rd_wren, 0);
        tick();
        idle();
        #1;
        check("t4_pending", pending, 0);
        tick();

        // Same-cycle set/clear of x9, then reset mid-stream
        lu_issue = 1; lu_issue_rd = 5'd9;
        tick();
        lu_valid = 1; lu_rd = 5'd9; lu_data = 32'h9;
        #1;
        check("t5_ret_ready", lu_ready, 1);
        tick();
        lu_valid = 0; lu_issue_rd = 5'd3;
        #1;
        check("t5_set_wins", pending, 32'h200);
        tick();
        lu_issue = 0;
        #1;
        check("t5_pending_208", pending, 32'h208);
        core_wren = 1; core_rd = 5'd5; lu_valid = 1; lu_rd = 5'd12; lu_data = 32'hC;
        rst_n = 0;
        #1;
        check("t5_rst_pending", pending, 0);
        check("t5_rst_wren", rd_wren, 0);
        check("t5_rst_ready", lu_ready, 0);
        tick();
        rst_n = 1;
        #1;
        check("t5_normal_ready", lu_ready, 0);
        check("t5_normal_addr", rd_addr, 5);
        core_wren = 0;
        #1;
        check("t5_inflight_ready", lu_ready, 1);
        check("t5_inflight_addr", rd_addr, 12);
        check("t5_inflight_wren", rd_wren, 1);
        tick();
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_rf_wb_arbiter

`default_nettype wire
